// File: rtl/jk_excite_counter.sv
// jk_excite_counter: modulo up/down counter built from a JK register bank.
// Each cycle a target next value n is chosen (load > en > hold); the per-bit
// J/K excitation is derived from q and n, and the bank follows the JK rule.
// Optional build macro: JK_CNT_SATURATE_EN -- saturate at the count limits
// instead of wrapping (default build wraps).
module jk_excite_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc
);

  // One extra bit so MODULUS = 2**WIDTH has headroom for q+1 and the limit.
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [EW-1:0] TOP = EW'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] n;
  logic [EW-1:0]    q_ext;
  logic [EW-1:0]    ld_ext;
  logic [EW-1:0]    inc_ext;
  logic [EW-1:0]    dec_ext;
  logic [EW-1:0]    n_ext;
  logic             q_in_range;
  logic             at_term;
  logic             unused_n_msb;

  // Target next value selection and terminal-count detection.
  always_comb begin
    q_ext      = {1'b0, q_q};
    ld_ext     = {1'b0, load_val};
    inc_ext    = q_ext + EW'(1);
    dec_ext    = q_ext - EW'(1);
    q_in_range = (q_ext <= TOP);
    at_term    = up ? (q_ext == TOP) : (q_ext == EW'(0));
    n_ext      = q_ext;
    if (load) begin
      n_ext = (ld_ext <= TOP) ? ld_ext : TOP;
    end else if (en) begin
      if (!q_in_range) begin
        n_ext = TOP;
      end else if (at_term) begin
`ifdef JK_CNT_SATURATE_EN
        n_ext = q_ext;
`else
        n_ext = up ? EW'(0) : TOP;
`endif
      end else begin
        n_ext = up ? inc_ext : dec_ext;
      end
    end
    n = n_ext[WIDTH-1:0];
  end

  // n never exceeds TOP, so its extension bit carries no information.
  assign unused_n_msb = n_ext[WIDTH];

  // Per-bit excitation (never 11) and the JK characteristic equation.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    tc    = 1'b0;
    if (!rst) begin
      j_vec = ~q_q & n;
      k_vec = q_q & ~n;
      tc    = en & ~load & at_term;
    end
    q_d = (j_vec & ~q_q) | (~k_vec & q_q);
  end

  // JK register bank; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: tb/tb_jk_excite_counter.sv
// Directed self-checking bench for jk_excite_counter (WIDTH=4, MODULUS=10).
module tb_jk_excite_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       tc;

  int checks;
  int errors;

  jk_excite_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .q_bar    (q_bar),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: synchronous load of v, then idle inputs.
  task automatic do_load(input logic [3:0] v);
    @(negedge clk);
    load = 1'b1; en = 1'b0; load_val = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd5;
    #2;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
    checks++;
    if (q_bar !== 4'hF) begin errors++; $display("FAIL reset_qbar: got %h want f", q_bar); end
    checks++;
    if (j_vec !== 4'd0 || k_vec !== 4'd0) begin
      errors++; $display("FAIL reset_jk: got j=%b k=%b want 0000/0000", j_vec, k_vec);
    end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", tc); end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_hold_q: got %h want 0", q); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_load(4'd7);
    checks++;
    if (q !== 4'd7) begin errors++; $display("FAIL midrst_preload: got %h want 7", q); end
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || q_bar !== 4'hF) begin
      errors++; $display("FAIL midrst_async: got q=%h qbar=%h want 0/f", q, q_bar);
    end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL midrst_tc: got %b want 0", tc); end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd1) begin errors++; $display("FAIL midrst_resume: got %h want 1", q); end
    en = 1'b0;
  endtask

  task automatic test_up_count();
    logic [3:0] wrap_exp;
`ifdef JK_CNT_SATURATE_EN
    wrap_exp = 4'd9;
`else
    wrap_exp = 4'd0;
`endif
    do_load(4'd0);
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (q !== 4'(i)) begin errors++; $display("FAIL up_q[%0d]: got %h want %h", i, q, 4'(i)); end
      checks++;
      if (tc !== (i == 9)) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, (i == 9)); end
      checks++;
      if ((j_vec & k_vec) !== 4'd0) begin
        errors++; $display("FAIL up_jk_excl[%0d]: got j=%b k=%b", i, j_vec, k_vec);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (q !== wrap_exp) begin errors++; $display("FAIL up_wrap: got %h want %h", q, wrap_exp); end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] wrap_exp;
`ifdef JK_CNT_SATURATE_EN
    wrap_exp = 4'd0;
`else
    wrap_exp = 4'd9;
`endif
    do_load(4'd0);
    @(negedge clk);
    en = 1'b1; up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at0: got %b want 1", tc); end
    @(posedge clk);
    #1;
    checks++;
    if (q !== wrap_exp) begin errors++; $display("FAIL down_wrap: got %h want %h", q, wrap_exp); end
    do_load(4'd9);
    @(negedge clk);
    en = 1'b1; up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL down_tc_at9: got %b want 0", tc); end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd8) begin errors++; $display("FAIL down_step: got %h want 8", q); end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    logic [3:0] vals [4];
    logic [3:0] exps [4];
    vals = '{4'd12, 4'd9, 4'd10, 4'd4};
    exps = '{4'd9,  4'd9, 4'd9,  4'd4};
    do_load(4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load = 1'b1; en = 1'b1; up = 1'b0; load_val = vals[i];
      #1;
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL load_tc[%0d]: got %b want 0", i, tc); end
      @(posedge clk);
      #1;
      checks++;
      if (q !== exps[i]) begin errors++; $display("FAIL load_q[%0d]: got %h want %h", i, q, exps[i]); end
    end
    // Load overrides en/up at the terminal value too.
    @(negedge clk);
    load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd15;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL load_tc_term: got %b want 0", tc); end
    @(posedge clk);
    #1;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_excitation();
    do_load(4'd5);
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    #1;
    checks++;
    if (j_vec !== 4'b0010 || k_vec !== 4'b0001) begin
      errors++; $display("FAIL exc_5up: got j=%b k=%b want 0010/0001", j_vec, k_vec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd6) begin errors++; $display("FAIL exc_5up_q: got %h want 6", q); end
    do_load(4'd7);
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    #1;
    checks++;
    if (j_vec !== 4'b1000 || k_vec !== 4'b0111) begin
      errors++; $display("FAIL exc_7up: got j=%b k=%b want 1000/0111", j_vec, k_vec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd8) begin errors++; $display("FAIL exc_7up_q: got %h want 8", q); end
    @(negedge clk);
    up = 1'b0;
    #1;
    checks++;
    if (j_vec !== 4'b0111 || k_vec !== 4'b1000) begin
      errors++; $display("FAIL exc_8dn: got j=%b k=%b want 0111/1000", j_vec, k_vec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'd7 || q_bar !== 4'b1000) begin
      errors++; $display("FAIL exc_8dn_q: got q=%h qbar=%h want 7/8", q, q_bar);
    end
    en = 1'b0;
  endtask

  task automatic test_hold();
    do_load(4'd4);
    @(negedge clk);
    en = 1'b0; load = 1'b0; up = 1'b1; load_val = 4'd8;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin
        errors++; $display("FAIL hold_jk[%0d]: got j=%b k=%b tc=%b want 0000/0000/0", i, j_vec, k_vec, tc);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q !== 4'd4) begin errors++; $display("FAIL hold_q[%0d]: got %h want 4", i, q); end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_mid_reset();
    test_up_count();
    test_down_wrap();
    test_load_clamp();
    test_excitation();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excite_counter.md
JK_EXCITE_COUNTER -- requirements
Module: jk_excite_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register bank width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  WIDTH  value applied on load.
REQ-009 SHALL have port q  output  WIDTH  JK register bank state (count).
REQ-010 SHALL have port q_bar  output  WIDTH  bitwise complement of q.
REQ-011 SHALL have port j_vec  output  WIDTH  per-bit J excitation driving the bank.
REQ-012 SHALL have port k_vec  output  WIDTH  per-bit K excitation driving the bank.
REQ-013 SHALL have port tc  output  1  terminal-count pulse.

Function
REQ-014 SHALL compute a target next value n each cycle, then derive per-bit excitation j_vec[i] = ~q[i] & n[i], k_vec[i] = q[i] & ~n[i] (hold = 00, never 11).
REQ-015 SHALL update each bank bit on the rising clk edge per the JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-016 SHALL select n by priority: load, then en, else n = q (j_vec = k_vec = 0).
REQ-017 SHALL on load set n = load_val when load_val < MODULUS, else n = MODULUS-1 (clamp); en and up ignored that cycle.
REQ-018 SHALL on en with up=1 set n = q+1, and at q = MODULUS-1 set n = 0 (wrap).
REQ-019 SHALL on en with up=0 set n = q-1, and at q = 0 set n = MODULUS-1 (wrap).
REQ-020 SHALL drive tc combinationally high when en=1, load=0 and q is at the terminal value for the current direction (MODULUS-1 up, 0 down), else low.
REQ-021 SHALL compute all arithmetic in WIDTH+1 bits so MODULUS = 2**WIDTH wraps without overflow artefacts.
REQ-022 SHALL keep q_bar = ~q at all times, including during reset.
REQ-023 SHALL, if q is ever outside 0..MODULUS-1, load the clamp value MODULUS-1 on the next en or load cycle.

Reset
REQ-024 SHALL on rst=1 immediately, without a clock edge, force q = 0 and q_bar = all ones.
REQ-025 SHALL hold j_vec = k_vec = 0 and tc = 0 while rst=1, regardless of other inputs.
REQ-026 SHALL resume counting on the first rising clk edge after rst deasserts; a reset asserted mid-count discards the pending update.

Configuration
REQ-027 SHALL support macro JK_CNT_SATURATE_EN: when defined, count saturates at MODULUS-1 (up) and 0 (down) instead of wrapping, with j_vec = k_vec = 0 at the limit; tc still asserts at the limit.
REQ-028 SHALL, when JK_CNT_SATURATE_EN is not defined, wrap as in REQ-018/REQ-019.

Verification
REQ-029 SHALL cover: rst pulse mid-cycle with q=7 -> q=0, q_bar=4'hF before next clk edge, tc=0.
REQ-030 SHALL cover: en=1, up=1 from 0 for 10 edges, MODULUS=10 -> q steps 0..9 then 0; tc high only while q=9.
REQ-031 SHALL cover: en=1, up=0 from q=0 -> q=9 next edge, tc high in the q=0 cycle; with JK_CNT_SATURATE_EN q stays 0.
REQ-032 SHALL cover: load=1, en=1, load_val=12 at q=3 -> q=9 next edge, tc=0 that cycle.
REQ-033 SHALL cover: q=5 (0101) up-count -> j_vec=0010, k_vec=0001, q=6 next edge; j_vec&k_vec = 0 every cycle.
REQ-034 SHALL cover: en=0, load=0 for 5 edges at q=4 -> q stays 4, j_vec=k_vec=0, tc=0.
